// File: rtl/proc_pkg.sv
// Shared definitions for the 16-bit processor core.
// Holds the default register-index and data widths and the operand-fetch
// sequencer state encoding.
package proc_pkg;

  localparam int DFLT_ADDRESS_LEN = 4;
  localparam int DFLT_DATA_LEN    = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    EXEC  = 3'd4,
    WB    = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/operand_fetch_seq.sv
// Operand fetch / writeback sequencer: reads src_a then src_b through the single
// register-file read port, starts the ALU, waits for alu_done, optionally writes back.
// Latency: accept to alu_start 4 edges; accept to write commit 6 edges minimum.
// Backpressure: instr_ready_o high only in IDLE; instr_valid_i ignored while busy.
//
// Ports: clk_i/rst_ni (async active-low); instr_valid_i/instr_ready_o with
// src_a_i/src_b_i/dst_i/wb_req_i; rd_addr_o/rd_data_i to the register file read
// port; opa_o/opb_o/alu_start_o/alu_done_i/alu_result_i to the ALU;
// rf_wr_en_o/wr_addr_o/wr_data_o to the register file write port; busy_o.
module operand_fetch_seq
  import proc_pkg::*;
#(
  parameter int ADDRESS_LEN = DFLT_ADDRESS_LEN,
  parameter int DATA_LEN    = DFLT_DATA_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   instr_valid_i,
  output logic                   instr_ready_o,
  input  logic [ADDRESS_LEN-1:0] src_a_i,
  input  logic [ADDRESS_LEN-1:0] src_b_i,
  input  logic [ADDRESS_LEN-1:0] dst_i,
  input  logic                   wb_req_i,
  output logic [ADDRESS_LEN-1:0] rd_addr_o,
  input  logic [DATA_LEN-1:0]    rd_data_i,
  output logic [DATA_LEN-1:0]    opa_o,
  output logic [DATA_LEN-1:0]    opb_o,
  output logic                   alu_start_o,
  input  logic                   alu_done_i,
  input  logic [DATA_LEN-1:0]    alu_result_i,
  output logic                   rf_wr_en_o,
  output logic [ADDRESS_LEN-1:0] wr_addr_o,
  output logic [DATA_LEN-1:0]    wr_data_o,
  output logic                   busy_o
);

  fetch_state_t           state_q, state_d;
  logic [ADDRESS_LEN-1:0] src_b_q, src_b_d;
  logic [ADDRESS_LEN-1:0] dst_q, dst_d;
  logic                   wb_q, wb_d;
  logic [ADDRESS_LEN-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_LEN-1:0]    opa_q, opa_d;
  logic [DATA_LEN-1:0]    opb_q, opb_d;
  logic                   alu_start_q, alu_start_d;
  logic                   rf_wr_en_q, rf_wr_en_d;
  logic [ADDRESS_LEN-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_LEN-1:0]    wr_data_q, wr_data_d;
  logic                   instr_ready_q, instr_ready_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d       = state_q;
    src_b_d       = src_b_q;
    dst_d         = dst_q;
    wb_d          = wb_q;
    rd_addr_d     = rd_addr_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    instr_ready_d = instr_ready_q;
    busy_d        = busy_q;
    // Single-cycle pulses: low unless the current state raises them.
    alu_start_d   = 1'b0;
    rf_wr_en_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (instr_valid_i && instr_ready_q) begin
          // src_a goes straight onto the read port; only src_b/dst/wb need holding.
          src_b_d       = src_b_i;
          dst_d         = dst_i;
          wb_d          = wb_req_i;
          rd_addr_d     = src_a_i;
          instr_ready_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = RD_A;
        end
      end
      RD_A: begin
        rd_addr_d = src_b_q;
        state_d   = RD_B;
      end
      RD_B: begin
        // Register file returns R[src_a] one cycle after sampling the address.
        opa_d   = rd_data_i;
        state_d = CAP_B;
      end
      CAP_B: begin
        opb_d       = rd_data_i;
        alu_start_d = 1'b1;
        state_d     = EXEC;
      end
      EXEC: begin
        if (alu_done_i) begin
          if (wb_q) begin
            wr_addr_d  = dst_q;
            wr_data_d  = alu_result_i;
            rf_wr_en_d = 1'b1;
            state_d    = WB;
          end else begin
            instr_ready_d = 1'b1;
            busy_d        = 1'b0;
            state_d       = IDLE;
          end
        end
      end
      WB: begin
        // Register file commits at the end of this cycle.
        instr_ready_d = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
      default: begin
        instr_ready_d = 1'b1;
        busy_d        = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      src_b_q       <= '0;
      dst_q         <= '0;
      wb_q          <= 1'b0;
      rd_addr_q     <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      alu_start_q   <= 1'b0;
      rf_wr_en_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      instr_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_b_q       <= src_b_d;
      dst_q         <= dst_d;
      wb_q          <= wb_d;
      rd_addr_q     <= rd_addr_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      alu_start_q   <= alu_start_d;
      rf_wr_en_q    <= rf_wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      instr_ready_q <= instr_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign instr_ready_o = instr_ready_q;
  assign busy_o        = busy_q;
  assign rd_addr_o     = rd_addr_q;
  assign opa_o         = opa_q;
  assign opb_o         = opb_q;
  assign alu_start_o   = alu_start_q;
  assign rf_wr_en_o    = rf_wr_en_q;
  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Bench for operand_fetch_seq with a behavioural register file and ALU.
// Stimulus pushes expected operands and writebacks into queues; a negedge
// monitor pops and compares whenever alu_start or rf_wr_en is seen.
module tb_operand_fetch_seq;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid, instr_ready, wb_req;
  logic [3:0]  src_a, src_b, dst, rd_addr, wr_addr;
  logic [15:0] rd_data, opa, opb, alu_result, wr_data;
  logic        alu_start, alu_done, rf_wr_en, busy;

  always #5 clk = ~clk;

  operand_fetch_seq #(.ADDRESS_LEN(4), .DATA_LEN(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .src_a_i(src_a), .src_b_i(src_b), .dst_i(dst), .wb_req_i(wb_req),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .opa_o(opa), .opb_o(opb), .alu_start_o(alu_start),
    .alu_done_i(alu_done), .alu_result_i(alu_result),
    .rf_wr_en_o(rf_wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy)
  );

  // Behavioural register file: registered read, bench preload port.
  logic [15:0] rf_mem [16];
  logic        pre_we = 1'b0;
  logic [3:0]  pre_addr = '0;
  logic [15:0] pre_data = '0;
  always @(posedge clk) begin
    rd_data <= rf_mem[rd_addr];
    if (rf_wr_en) rf_mem[wr_addr] <= wr_data;
    else if (pre_we) rf_mem[pre_addr] <= pre_data;
  end

  // Behavioural ALU: done alu_lat cycles after alu_start (0 = same cycle).
  logic        alu_fixed = 1'b1;
  logic [15:0] alu_res = '0;
  int          alu_lat = 0;
  logic        alu_busy;
  int          alu_cnt;
  logic        alu_noise = 1'b0;
  assign alu_done   = alu_noise || (alu_start && alu_lat == 0) || (alu_busy && alu_cnt == 0);
  assign alu_result = alu_fixed ? alu_res : (opa + opb);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_busy <= 1'b0;
      alu_cnt  <= 0;
    end else if (alu_start && alu_lat != 0) begin
      alu_busy <= 1'b1;
      alu_cnt  <= alu_lat - 1;
    end else if (alu_busy) begin
      if (alu_cnt == 0) alu_busy <= 1'b0;
      else alu_cnt <= alu_cnt - 1;
    end
  end

  typedef struct { logic [15:0] a; logic [15:0] b; } op_exp_t;
  typedef struct { logic [3:0] addr; logic [15:0] data; } wb_exp_t;
  op_exp_t     op_q[$];
  wb_exp_t     wb_q[$];
  logic [15:0] model [16];
  int          checks = 0, failures = 0;
  int          wr_seen = 0, wb_ok = 0;
  logic        rand_phase = 1'b0;
  logic        prev_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  op_exp_t mo_e;
  wb_exp_t mw_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b0;
    end else begin
      if (alu_start) begin
        if (op_q.size() == 0) begin
          check("unexpected_alu_start", 1, 0);
        end else begin
          mo_e = op_q.pop_front();
          check("operands_at_start", {opa, opb}, {mo_e.a, mo_e.b});
        end
      end
      if (rf_wr_en) begin
        wr_seen++;
        check("wr_en_single_cycle", prev_wr, 0);
        if (wb_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mw_e = wb_q.pop_front();
          check("writeback", {wr_addr, wr_data}, {mw_e.addr, mw_e.data});
          if (rand_phase && wr_addr == mw_e.addr && wr_data == mw_e.data) wb_ok++;
        end
      end
      prev_wr = rf_wr_en;
    end
  end

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    model[a] = d;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                       input logic wb, input logic exp_wb);
    int n = 0;
    logic [15:0] res;
    @(negedge clk);
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout: instr_ready still %b after 50 cycles", instr_ready);
    end
    op_q.push_back('{a: model[a], b: model[b]});
    res = alu_fixed ? alu_res : (model[a] + model[b]);
    if (wb && exp_wb) begin
      wb_q.push_back('{addr: d, data: res});
      model[d] = res;
    end
    instr_valid = 1'b1; src_a = a; src_b = b; dst = d; wb_req = wb;
    @(posedge clk); #1;
    instr_valid = 1'b0; src_a = ~a; src_b = ~b; dst = ~d; wb_req = ~wb;
    check("accepted_ready_low", instr_ready, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!instr_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL idle_timeout: instr_ready still %b after 100 cycles", instr_ready);
    end
  endtask

  initial begin
    int ws, bad;
    logic [15:0] keep;
    instr_valid = 0; src_a = 0; src_b = 0; dst = 0; wb_req = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr_ready", instr_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_outputs_zero", {alu_start, rf_wr_en, rd_addr, wr_addr}, 0);
    check("rst_data_zero", {opa, opb}, 0);
    check("rst_wr_data_zero", wr_data, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 16; i++) preload(i[3:0], 16'h1000 + 16'(i));
    preload(4'd3, 16'h1234);
    preload(4'd7, 16'hABCD);
    preload(4'd5, 16'h00FF);

    // 1 Basic
    alu_fixed = 1'b1; alu_res = 16'hBEEF; alu_lat = 2;
    ws = wr_seen;
    issue(4'd3, 4'd7, 4'd9, 1'b1, 1'b1);
    wait_idle();
    check("basic_r9", rf_mem[9], 16'hBEEF);
    check("basic_one_write", wr_seen - ws, 1);
    check("basic_opa_held", opa, 16'h1234);
    check("basic_opb_held", opb, 16'hABCD);

    // 2 Latency with combinational ALU
    alu_res = 16'h5A5A; alu_lat = 0;
    issue(4'd1, 4'd2, 4'd4, 1'b1, 1'b1);
    for (int e = 2; e <= 6; e++) begin
      @(posedge clk); #1;
      check($sformatf("lat_alu_start_e%0d", e), alu_start, (e == 4));
      check($sformatf("lat_wr_en_e%0d", e), rf_wr_en, (e == 5));
      check($sformatf("lat_ready_e%0d", e), instr_ready, (e == 6));
    end
    check("lat_r4", rf_mem[4], 16'h5A5A);

    // 3 No writeback, aliased sources/destination
    alu_res = 16'h7777; alu_lat = 1;
    ws = wr_seen;
    issue(4'd5, 4'd5, 4'd5, 1'b0, 1'b1);
    wait_idle();
    check("nowb_no_write", wr_seen - ws, 0);
    check("nowb_r5", rf_mem[5], 16'h00FF);
    check("nowb_opa_eq_opb", {opa, opb}, {16'h00FF, 16'h00FF});

    // 4 Stall in EXEC, noise during RD_A/RD_B
    alu_res = 16'h4242; alu_lat = 21;
    issue(4'd6, 4'd8, 4'd10, 1'b1, 1'b1);
    alu_noise = 1'b1; instr_valid = 1'b1; src_a = 4'hF; src_b = 4'hE; dst = 4'hD; wb_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    alu_noise = 1'b0;
    @(posedge clk); #1;
    check("stall_alu_start", alu_start, 1);
    bad = 0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      if (dut.state_q != EXEC || instr_ready || !busy || rf_wr_en) bad++;
    end
    instr_valid = 1'b0;
    check("stall_bad_cycles", bad, 0);
    wait_idle();
    check("stall_r10", rf_mem[10], 16'h4242);
    check("stall_no_extra_accept", op_q.size(), 0);

    // 5 Reset while in WB
    alu_res = 16'hDEAD; alu_lat = 0;
    keep = model[11];
    issue(4'd1, 4'd2, 4'd11, 1'b1, 1'b0);
    bad = 0;
    while (!rf_wr_en && bad < 10) begin @(posedge clk); #1; bad++; end
    check("rstwb_reached_wb", rf_wr_en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rstwb_wr_en_low", rf_wr_en, 0);
    check("rstwb_ready", instr_ready, 1);
    check("rstwb_busy", busy, 0);
    @(posedge clk); #1;
    check("rstwb_r11_unchanged", rf_mem[11], keep);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstwb_ready_after", instr_ready, 1);

    // 6 Random writebacks
    alu_fixed = 1'b0; rand_phase = 1'b1; wb_ok = 0;
    for (int k = 0; k < 100; k++) begin
      alu_lat = $urandom_range(0, 3);
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b1);
      wait_idle();
    end
    @(negedge clk);
    rand_phase = 1'b0;
    $display("random writebacks matched: %0d/100", wb_ok);
    check("random_wb_ok", wb_ok, 100);
    for (int i = 0; i < 16; i++) check($sformatf("final_r%0d", i), rf_mem[i], model[i]);
    check("queues_drained", op_q.size() + wb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
